// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Pipeline MEM stage: data-memory access, stack pointer and CALL/RET/RTI sequencing.
module memory_stage #(
   parameter int                ADDR_W  = 16,
   parameter logic [ADDR_W-1:0] SP_INIT = 16'hFFFF
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [105:0]      In,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              mem_we,
   input  logic [15:0]       mem_rdata,
   output logic              stall,
   output logic              pc_load,
   output logic [31:0]       pc_value,
   output logic              flags_load,
   output logic [2:0]        flags_value,
   output logic              wb_en,
   output logic [2:0]        wb_addr,
   output logic [15:0]       wb_data,
   output logic [15:0]       out_port,
   output logic [19:0]       Fwd_mem
);

   typedef enum logic [2:0] {IDLE, CALL2, RET2, RTI2, RTI3} state_t;

   state_t            state;
   logic [ADDR_W-1:0] sp;
   logic [15:0]       holdWord;

   logic [15:0] inPort, rsrcVal, aluRes;
   logic [31:0] nextPc;
   logic [2:0]  rdstAddr;
   logic        isPush, isPop, isRet, isRti, isIn, isOut, isCall, isRead, isWrite, isBubble;
   logic        unusedBits;

   assign inPort   = In[98:83];
   assign nextPc   = In[82:51];
   assign rsrcVal  = In[50:35];
   assign aluRes   = In[34:19];
   assign rdstAddr = In[15:13];
   assign isPush   = In[11];
   assign isPop    = In[10];
   assign isRet    = In[9];
   assign isRti    = In[8];
   assign isRead   = In[7] | In[2];
   assign isIn     = In[6];
   assign isOut    = In[5];
   assign isCall   = In[3];
   assign isWrite  = In[1];
   assign isBubble = ~|In[11:0];
   assign unusedBits = ^{In[105:99], In[18:16], In[12], In[4]};

   logic [ADDR_W-1:0] spP1, spP2, spP3, spM1, spM2;
   assign spP1 = sp + ADDR_W'(1);
   assign spP2 = sp + ADDR_W'(2);
   assign spP3 = sp + ADDR_W'(3);
   assign spM1 = sp - ADDR_W'(1);
   assign spM2 = sp - ADDR_W'(2);

   logic [ADDR_W-1:0] addrC;
   logic [15:0]       wdataC;
   logic              weC, stallC;

   // Stack ops outrank plain memory ops; reads are placed before writes so a read cycle never writes.
   always_comb begin
      addrC  = aluRes[ADDR_W-1:0];
      wdataC = rsrcVal;
      weC    = 1'b0;
      stallC = 1'b0;
      case (state)
         IDLE: begin
            if (isRti || isRet) begin
               addrC  = spP1;
               stallC = 1'b1;
            end else if (isCall) begin
               addrC  = sp;
               wdataC = nextPc[31:16];
               weC    = 1'b1;
               stallC = 1'b1;
            end else if (isPush) begin
               addrC = sp;
               weC   = 1'b1;
            end else if (isPop) begin
               addrC = spP1;
            end else if (isWrite && !isRead) begin
               weC = 1'b1;
            end
         end
         CALL2: begin
            addrC  = spM1;
            wdataC = holdWord;
            weC    = 1'b1;
         end
         RET2: addrC = spP2;
         RTI2: begin
            addrC  = spP2;
            stallC = 1'b1;
         end
         RTI3: addrC = spP3;
         default: ;
      endcase
   end

   // Reset must silence the write strobe and freeze request before the flops settle.
   assign mem_addr  = addrC;
   assign mem_wdata = wdataC;
   assign mem_we    = weC & ~Reset;
   assign stall     = stallC & ~Reset;
   assign Fwd_mem   = {wb_en, wb_addr, wb_data};

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         sp          <= SP_INIT;
         holdWord    <= '0;
         wb_en       <= 1'b0;
         wb_addr     <= '0;
         wb_data     <= '0;
         out_port    <= '0;
         pc_load     <= 1'b0;
         pc_value    <= '0;
         flags_load  <= 1'b0;
         flags_value <= '0;
      end else begin
         pc_load    <= 1'b0;
         flags_load <= 1'b0;
         case (state)
            IDLE: begin
               if (isRti) begin
                  flags_value <= mem_rdata[2:0];
                  wb_en       <= 1'b0;
                  state       <= RTI2;
               end else if (isRet) begin
                  holdWord <= mem_rdata;
                  wb_en    <= 1'b0;
                  state    <= RET2;
               end else if (isCall) begin
                  holdWord <= nextPc[15:0];
                  wb_en    <= 1'b0;
                  state    <= CALL2;
               end else if (isBubble) begin
                  wb_en <= 1'b0;
               end else begin
                  wb_en   <= In[0];
                  wb_addr <= rdstAddr;
                  if (isPush) begin
                     sp      <= spM1;
                     wb_data <= aluRes;
                  end else if (isPop) begin
                     sp      <= spP1;
                     wb_data <= mem_rdata;
                  end else if (isRead) begin
                     wb_data <= mem_rdata;
                  end else if (isWrite) begin
                     wb_data <= aluRes;
                  end else if (isIn) begin
                     wb_data <= inPort;
                  end else if (isOut) begin
                     out_port <= rsrcVal;
                     wb_en    <= 1'b0;
                  end else begin
                     wb_data <= aluRes;
                  end
               end
            end
            CALL2: begin
               sp    <= spM2;
               wb_en <= 1'b0;
               state <= IDLE;
            end
            RET2: begin
               pc_value <= {mem_rdata, holdWord};
               pc_load  <= 1'b1;
               sp       <= spP2;
               wb_en    <= 1'b0;
               state    <= IDLE;
            end
            RTI2: begin
               holdWord <= mem_rdata;
               wb_en    <= 1'b0;
               state    <= RTI3;
            end
            RTI3: begin
               pc_value   <= {mem_rdata, holdWord};
               pc_load    <= 1'b1;
               flags_load <= 1'b1;
               sp         <= spP3;
               wb_en      <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - Directed self-checking bench for memory_stage.
module tb_memory_stage;

   localparam logic [11:0] C_PUSH = 12'h800, C_POP = 12'h400, C_RET = 12'h200, C_RTI = 12'h100;
   localparam logic [11:0] C_LDD = 12'h080, C_IN = 12'h040, C_OUT = 12'h020, C_CALL = 12'h008;
   localparam logic [11:0] C_MR = 12'h004, C_MW = 12'h002, C_WB = 12'h001;

   logic         CLK, Reset;
   logic [105:0] In;
   logic [15:0]  mem_addr, mem_wdata, mem_rdata, wb_data, out_port;
   logic         mem_we, stall, pc_load, flags_load, wb_en;
   logic [31:0]  pc_value;
   logic [2:0]   flags_value, wb_addr;
   logic [19:0]  Fwd_mem;
   logic [15:0]  tbMem [0:65535];

   int compared = 0;
   int mismatched = 0;

   memory_stage #(.ADDR_W(16), .SP_INIT(16'hFFFF)) dut (
      .CLK(CLK), .Reset(Reset), .In(In),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .stall(stall), .pc_load(pc_load), .pc_value(pc_value),
      .flags_load(flags_load), .flags_value(flags_value),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_port(out_port), .Fwd_mem(Fwd_mem)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   assign mem_rdata = tbMem[mem_addr];
   always @(posedge CLK) if (mem_we) tbMem[mem_addr] <= mem_wdata;

   function automatic logic [105:0] mk(input logic [11:0] ctl, input logic [2:0] rdst,
                                       input logic [15:0] rsrc, input logic [15:0] alu,
                                       input logic [31:0] pc, input logic [15:0] inp);
      return {7'b0, inp, pc, rsrc, alu, 3'b0, rdst, 1'b0, ctl};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clk1();
      @(posedge CLK);
      #1;
   endtask

   // SP is internal: present a PUSH combinationally and read the address it would use.
   task automatic chkSp(input string tag, input logic [15:0] exp);
      logic [105:0] saved;
      saved = In;
      In = mk(C_PUSH, 3'd0, 16'h0, 16'h0, 32'h0, 16'h0);
      #1;
      chk(tag, 32'(mem_addr), 32'(exp));
      In = saved;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) tbMem[i] = 16'h0;
      Reset = 1'b1;
      In = '0;
      #3;
      chk("rst_wb_en", 32'(wb_en), 32'd0);
      chk("rst_wb_data", 32'(wb_data), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_pc_load", 32'(pc_load), 32'd0);
      chk("rst_out_port", 32'(out_port), 32'd0);
      @(posedge CLK);
      #1 Reset = 1'b0;

      // Reset during CALL2
      In = mk(C_CALL, 3'd0, 16'h0, 16'h0, 32'h0001_0020, 16'h0);
      #1;
      chk("call1_stall", 32'(stall), 32'd1);
      chk("call1_we", 32'(mem_we), 32'd1);
      chk("call1_addr", 32'(mem_addr), 32'hFFFF);
      chk("call1_wdata", 32'(mem_wdata), 32'h0001);
      clk1();
      chk("call2_addr", 32'(mem_addr), 32'hFFFE);
      chk("call2_wdata", 32'(mem_wdata), 32'h0020);
      Reset = 1'b1;
      #1;
      chk("midrst_stall", 32'(stall), 32'd0);
      chk("midrst_we", 32'(mem_we), 32'd0);
      chk("midrst_wb_en", 32'(wb_en), 32'd0);
      In = '0;
      clk1();
      Reset = 1'b0;
      chkSp("midrst_sp", 16'hFFFF);

      // PUSH then POP
      In = mk(C_PUSH, 3'd0, 16'h1234, 16'h0, 32'h0, 16'h0);
      clk1();
      chk("push_mem", 32'(tbMem[16'hFFFF]), 32'h1234);
      chkSp("push_sp", 16'hFFFE);
      In = mk(C_POP | C_WB, 3'd3, 16'h0, 16'h0, 32'h0, 16'h0);
      #1;
      chk("pop_addr", 32'(mem_addr), 32'hFFFF);
      clk1();
      In = '0;
      chk("pop_wb_en", 32'(wb_en), 32'd1);
      chk("pop_wb_addr", 32'(wb_addr), 32'd3);
      chk("pop_wb_data", 32'(wb_data), 32'h1234);
      chkSp("pop_sp", 16'hFFFF);

      // CALL
      In = mk(C_CALL, 3'd0, 16'h0, 16'h0, 32'h0001_0020, 16'h0);
      #1;
      chk("call_stall_c1", 32'(stall), 32'd1);
      clk1();
      chk("call_stall_c2", 32'(stall), 32'd0);
      clk1();
      In = '0;
      #1;
      chk("call_stall_after", 32'(stall), 32'd0);
      chk("call_mem_hi", 32'(tbMem[16'hFFFF]), 32'h0001);
      chk("call_mem_lo", 32'(tbMem[16'hFFFE]), 32'h0020);
      chk("call_wb_en", 32'(wb_en), 32'd0);
      chkSp("call_sp", 16'hFFFD);

      // RET
      In = mk(C_RET, 3'd0, 16'h0, 16'h0, 32'h0, 16'h0);
      #1;
      chk("ret_r1_stall", 32'(stall), 32'd1);
      chk("ret_r1_addr", 32'(mem_addr), 32'hFFFE);
      clk1();
      chk("ret_r2_stall", 32'(stall), 32'd0);
      chk("ret_r2_addr", 32'(mem_addr), 32'hFFFF);
      clk1();
      In = '0;
      chk("ret_pc_load", 32'(pc_load), 32'd1);
      chk("ret_pc_value", pc_value, 32'h0001_0020);
      clk1();
      chk("ret_pc_load_drop", 32'(pc_load), 32'd0);
      chkSp("ret_sp", 16'hFFFF);

      // RTI frame built with three pushes
      In = mk(C_PUSH, 3'd0, 16'h0000, 16'h0, 32'h0, 16'h0);
      clk1();
      In = mk(C_PUSH, 3'd0, 16'h0040, 16'h0, 32'h0, 16'h0);
      clk1();
      In = mk(C_PUSH, 3'd0, 16'h0005, 16'h0, 32'h0, 16'h0);
      clk1();
      chkSp("rti_pre_sp", 16'hFFFC);
      In = mk(C_RTI, 3'd0, 16'h0, 16'h0, 32'h0, 16'h0);
      #1;
      chk("rti_t1_stall", 32'(stall), 32'd1);
      clk1();
      chk("rti_t2_stall", 32'(stall), 32'd1);
      chk("rti_flags", 32'(flags_value), 32'd5);
      clk1();
      chk("rti_t3_stall", 32'(stall), 32'd0);
      clk1();
      In = '0;
      chk("rti_pc_load", 32'(pc_load), 32'd1);
      chk("rti_flags_load", 32'(flags_load), 32'd1);
      chk("rti_pc_value", pc_value, 32'h0000_0040);
      clk1();
      chk("rti_pulse_drop", 32'({pc_load, flags_load}), 32'd0);
      chkSp("rti_sp", 16'hFFFF);

      // STD then LDD
      In = mk(C_MW, 3'd0, 16'hBEEF, 16'h0010, 32'h0, 16'h0);
      #1;
      chk("std_we", 32'(mem_we), 32'd1);
      chk("std_addr", 32'(mem_addr), 32'h0010);
      clk1();
      chk("std_mem", 32'(tbMem[16'h0010]), 32'hBEEF);
      In = mk(C_LDD | C_MR | C_WB, 3'd5, 16'h0, 16'h0010, 32'h0, 16'h0);
      #1;
      chk("ldd_we", 32'(mem_we), 32'd0);
      clk1();
      chk("ldd_wb_data", 32'(wb_data), 32'hBEEF);
      chk("ldd_fwd", 32'(Fwd_mem), 32'h000D_BEEF);

      // IN, OUT, ALU, bubble
      In = mk(C_IN | C_WB, 3'd2, 16'h0, 16'h0, 32'h0, 16'h55AA);
      clk1();
      chk("in_wb_data", 32'(wb_data), 32'h55AA);
      chk("in_wb_addr", 32'(wb_addr), 32'd2);
      In = mk(C_OUT, 3'd0, 16'hCAFE, 16'h0, 32'h0, 16'h0);
      clk1();
      chk("out_port", 32'(out_port), 32'hCAFE);
      chk("out_wb_en", 32'(wb_en), 32'd0);
      In = mk(C_WB, 3'd1, 16'h0, 16'h7777, 32'h0, 16'h0);
      clk1();
      chk("alu_wb", 32'(Fwd_mem), 32'h0009_7777);
      In = '0;
      clk1();
      chk("bubble_fwd", 32'(Fwd_mem), 32'h0001_7777);

      // SP wraparound and priority
      In = mk(C_POP, 3'd0, 16'h0, 16'h0, 32'h0, 16'h0);
      #1;
      chk("wrap_pop_addr", 32'(mem_addr), 32'h0000);
      clk1();
      chkSp("wrap_pop_sp", 16'h0000);
      In = mk(C_PUSH, 3'd0, 16'hA5A5, 16'h0, 32'h0, 16'h0);
      clk1();
      chk("wrap_push_mem", 32'(tbMem[16'h0000]), 32'hA5A5);
      chkSp("wrap_push_sp", 16'hFFFF);
      In = mk(C_RTI | C_PUSH, 3'd0, 16'h0, 16'h0, 32'h0, 16'h0);
      #1;
      chk("prio_rti_stall", 32'(stall), 32'd1);
      chk("prio_rti_we", 32'(mem_we), 32'd0);
      In = mk(C_PUSH | C_MW, 3'd0, 16'h0, 16'h0010, 32'h0, 16'h0);
      #1;
      chk("prio_push_addr", 32'(mem_addr), 32'hFFFF);
      In = '0;
      clk1();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline MEM stage. Consumes the 106-bit execute-stage output bus from the EX/MEM register.
- Performs data-memory loads/stores and owns the stack pointer.
- Sequences multi-word stack transactions (CALL/RET/RTI), freezing upstream stages while it does so.
- Produces the registered MEM/WB result plus the 20-bit memory-stage forwarding field consumed by the execute stage.

Parameters:
- ADDR_W, 16, data-memory word-address width.
- SP_INIT, 16'hFFFF, stack pointer value after reset; the stack grows toward lower addresses.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- In  in  106  EX/MEM bus:
  - [105] CF, [104] NF, [103] ZF, [102] JMP, [101] JC, [100] JN, [99] JZ
  - [98:83] in-port value, [82:51] next PC, [50:35] Rsrc value, [34:19] ALU result
  - [18:16] Rsrc addr, [15:13] Rdst addr, [12] prev stack op
  - [11] PUSH, [10] POP, [9] RET, [8] RTI, [7] LDD, [6] IN, [5] OUT, [4] second iteration, [3] CALL, [2] MemRead, [1] MemWrite, [0] WB
- mem_addr  out  ADDR_W  data-memory word address.
- mem_wdata  out  16  write data.
- mem_we  out  1  write enable; the write occurs on the rising edge.
- mem_rdata  in  16  asynchronous read data for mem_addr.
- stall  out  1  freezes IF/ID/EX and the EX/MEM register while high.
- pc_load  out  1  one-cycle pulse: fetch must load pc_value.
- pc_value  out  32  return address restored by RET/RTI.
- flags_load  out  1  one-cycle pulse: restore the flag register from flags_value.
- flags_value  out  3  {CF,NF,ZF} popped by RTI.
- wb_en  out  1  registered writeback enable.
- wb_addr  out  3  registered destination register.
- wb_data  out  16  registered writeback data.
- out_port  out  16  OUT-instruction port register.
- Fwd_mem  out  20  {wb_en, wb_addr, wb_data}, i.e. the memory-stage forwarding field the execute stage consumes at Fwd[19:0].

Behaviour:
- Reset (asynchronous):
  - FSM goes to IDLE and SP goes to SP_INIT.
  - wb_en, wb_addr, wb_data, out_port, pc_load, pc_value, flags_load, flags_value, stall and mem_we all go to 0 immediately.
  - A transaction interrupted by reset is abandoned; there is no partial SP update beyond words already written.
- The bus is a bubble when In[11:1] and In[0] are all 0; a bubble only clears wb_en at the next edge.
- Single-cycle ops (IDLE, stall=0); registered outputs update at the closing edge:
  - LDD/MemRead, non-stack: mem_addr=ALU[ADDR_W-1:0]; wb_data<=mem_rdata.
  - STD/MemWrite, non-stack: mem_addr=ALU result, mem_wdata=Rsrc value, mem_we=1.
  - PUSH: mem_addr=SP, mem_wdata=Rsrc value, mem_we=1; SP<=SP-1.
  - POP: mem_addr=SP+1; wb_data<=mem_rdata; SP<=SP+1.
  - IN: wb_data<=in-port value.
  - OUT: out_port<=Rsrc value; wb_en<=0.
  - Otherwise wb_data<=ALU result.
  - In all single-cycle cases wb_en<=In[0] and wb_addr<=Rdst addr.
- CALL, 2 cycles:
  - C1: write PC[31:16] at SP, stall=1.
  - C2: write PC[15:0] at SP-1, stall=0, SP<=SP-2.
  - wb_en<=0.
- RET, 2 cycles:
  - R1: read SP+1 (low word) into an internal low-word holding register, stall=1.
  - R2: read SP+2 (high word); pc_value<={mem_rdata, held low}; pc_load=1 for one cycle after the edge; SP<=SP+2.
- RTI, 3 cycles:
  - T1: read SP+1; flags_value<=rdata[2:0].
  - T2: read SP+2 (low PC word).
  - T3: read SP+3 (high PC word).
  - After T3: pc_load and flags_load pulse together for one cycle; SP<=SP+3.
  - stall=1 in T1 and T2.
- FSM states: IDLE, CALL2, RET2, RTI2, RTI3.
  - From IDLE: CALL→CALL2, RET→RET2, RTI→RTI2.
  - RTI2→RTI3; all last states →IDLE.
  - Control bits are sampled only in IDLE; the held EX/MEM bus is ignored while in a non-IDLE state.
- SP arithmetic is modulo 2^ADDR_W: push at 16'h0000 wraps SP to 16'hFFFF; pop at 16'hFFFF reads address 0.
- Priority when multiple control bits are set: RTI > RET > CALL > PUSH > POP > memory > IN > OUT.
- mem_we is never asserted in a read cycle.

Test Plan:
- Assert Reset mid-CALL2 → stall, mem_we and wb_en are 0 at once; SP=16'hFFFF after release.
- PUSH with Rsrc=16'h1234 from reset → mem[FFFF]=1234, SP=FFFE. Then POP with Rdst=3 → wb_en=1, wb_addr=3, wb_data=1234, SP=FFFF.
- CALL with next PC=32'h0001_0020 → mem[FFFF]=0001, mem[FFFE]=0020, stall high exactly one cycle, SP=FFFD.
- RET immediately after that CALL → pc_value=32'h0001_0020, pc_load pulses one cycle, SP=FFFF.
- Preload mem[FFFD]=0005, mem[FFFE]=0040, mem[FFFF]=0000 with SP=FFFC, then RTI → stall high 2 cycles, flags_value=3'b101, pc_value=32'h0000_0040, SP=FFFF.
- STD with ALU=16'h0010 and Rsrc=16'hBEEF, then LDD with ALU=16'h0010 and Rdst=5 → wb_data=BEEF and Fwd_mem={1,3'd5,16'hBEEF}.
